poly_tone_synth: RTL and testbench

Parametrised polyphonic successor to the single-voice square-wave pitch generator. Mixes CHANNELS independent square-wave voices, each with its own note, octave, gate and volume, into one 1-bit sigma-delta stream that drives the buzzer pin. Voices share one time-multiplexed datapath that is swept once per sample tick. Sits between the note sources (piano keypad, music score controller) and the buzzer output.

---
 rtl/poly_tone_synth.sv | 263 ++++++++++++++++++++++++++
 tb/tb_poly_tone_synth.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_synth.sv
// poly_tone_synth: CHANNELS square-wave voices swept through one shared datapath per sample tick,
// summed and sent out as a 1-bit sigma-delta buzzer stream. Define RELEASE_EN for per-voice release envelopes.
module poly_tone_synth #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned SAMPLE_DIV  = 1024,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned VOL_W       = 4,
  parameter int unsigned RELEASE_DIV = 4096
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*CHANNELS-1:0]     ch_note,
  input  logic [4*CHANNELS-1:0]     ch_octave,
  input  logic [CHANNELS-1:0]       ch_gate,
  input  logic [VOL_W*CHANNELS-1:0] ch_volume,
  output logic                      wave,
  output logic [CHANNELS-1:0]       active
);

  localparam int unsigned SUM_W  = (CHANNELS > 1) ? VOL_W + $clog2(CHANNELS) : VOL_W + 1;
  localparam int unsigned SLOT_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W  = $clog2(SAMPLE_DIV);
`ifdef RELEASE_EN
  localparam int unsigned ENV_W  = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_LATCH = 2'd2;

  if (CHANNELS < 1 || CHANNELS > 16 || SAMPLE_DIV < CHANNELS + 2 ||
      ACC_W < 8 || ACC_W > 28 || RELEASE_DIV < 1) begin : g_param_check
    $error("poly_tone_synth: illegal parameter set");
  end

  // Octave-8 equal-tempered pitches in millihertz, C8..B8 (A8 = 7040 Hz).
  function automatic longint unsigned mhz_of(input int unsigned n);
    longint unsigned f;
    case (n)
      1:       f = 64'd4186009;
      2:       f = 64'd4434922;
      3:       f = 64'd4698636;
      4:       f = 64'd4978032;
      5:       f = 64'd5274041;
      6:       f = 64'd5587652;
      7:       f = 64'd5919911;
      8:       f = 64'd6271927;
      9:       f = 64'd6644875;
      10:      f = 64'd7040000;
      11:      f = 64'd7458620;
      12:      f = 64'd7902133;
      default: f = 64'd0;
    endcase
    return f;
  endfunction

  // Entry n sits at bits [n*ACC_W +: ACC_W]; built top-down by shifting so no variable slicing is needed.
  function automatic logic [16*ACC_W-1:0] build_inc_tab();
    logic [16*ACC_W-1:0] tab;
    longint unsigned     den;
    longint unsigned     num;
    tab = '0;
    den = 64'(CLK_HZ) * 64'd1000;
    for (int n = 15; n >= 0; n--) begin
      num = mhz_of(32'(n)) * (64'd1 << ACC_W) * 64'(SAMPLE_DIV);
      tab = (tab << ACC_W) | (16*ACC_W)'(ACC_W'((num + den / 64'd2) / den));
    end
    return tab;
  endfunction

  localparam logic [16*ACC_W-1:0] INC_TAB = build_inc_tab();

  logic [ACC_W-1:0]  inc_rom  [16];
  logic [3:0]        note_a   [CHANNELS];
  logic [3:0]        oct_a    [CHANNELS];
  logic [VOL_W-1:0]  vol_a    [CHANNELS];

  for (genvar g = 0; g < 16; g++) begin : g_rom
    assign inc_rom[g] = INC_TAB[g*ACC_W +: ACC_W];
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_unpack
    assign note_a[g] = ch_note[4*g +: 4];
    assign oct_a[g]  = ch_octave[4*g +: 4];
    assign vol_a[g]  = ch_volume[VOL_W*g +: VOL_W];
  end

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [SUM_W-1:0]    mix_q, mix_d;
  logic [SUM_W-1:0]    sd_q, sd_d;
  logic [SUM_W:0]      sd_sum;
  logic                wave_q, wave_d;
  logic [CHANNELS-1:0] active_q, active_d;
  logic [ACC_W-1:0]    acc_q [CHANNELS];
  logic [ACC_W-1:0]    acc_d [CHANNELS];

  logic                tick;
  logic [3:0]          note_s, oct_s;
  logic                gate_s, valid_s, act_new;
  logic [VOL_W-1:0]    vol_s, lvl_new, contrib;
  logic [ACC_W-1:0]    step, acc_new;

`ifdef RELEASE_EN
  logic [VOL_W-1:0]    lvl_q [CHANNELS];
  logic [VOL_W-1:0]    lvl_d [CHANNELS];
  logic [ENV_W-1:0]    env_q [CHANNELS];
  logic [ENV_W-1:0]    env_d [CHANNELS];
  logic [3:0]          hnote_q [CHANNELS];
  logic [3:0]          hnote_d [CHANNELS];
  logic [3:0]          hoct_q [CHANNELS];
  logic [3:0]          hoct_d [CHANNELS];
  logic [CHANNELS-1:0] gate_q, gate_d;
  logic [CHANNELS-1:0] rel_q, rel_d;
  logic [ENV_W-1:0]    env_new;
  logic                rel_new;
  logic [ACC_W-1:0]    step_hold;
`endif

  assign tick   = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign wave   = wave_q;
  assign active = active_q;

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + CNT_W'(1);
    state_d  = state_q;
    slot_d   = slot_q;
    sum_d    = sum_q;
    mix_d    = mix_q;
    active_d = active_q;
    acc_d    = acc_q;

    sd_sum = {1'b0, sd_q} + {1'b0, mix_q};
    sd_d   = sd_sum[SUM_W-1:0];
    wave_d = sd_sum[SUM_W];

    note_s  = note_a[slot_q];
    oct_s   = oct_a[slot_q];
    gate_s  = ch_gate[slot_q];
    vol_s   = vol_a[slot_q];
    valid_s = gate_s && (note_s >= 4'd1) && (note_s <= 4'd12) && (oct_s <= 4'd8);
    step    = inc_rom[note_s] >> (4'd8 - oct_s);
    acc_new = '0;
    lvl_new = '0;
    act_new = 1'b0;

`ifdef RELEASE_EN
    lvl_d     = lvl_q;
    env_d     = env_q;
    hnote_d   = hnote_q;
    hoct_d    = hoct_q;
    gate_d    = gate_q;
    rel_d     = rel_q;
    env_new   = '0;
    rel_new   = 1'b0;
    step_hold = inc_rom[hnote_q[slot_q]] >> (4'd8 - hoct_q[slot_q]);
    if (valid_s) begin
      acc_new = acc_q[slot_q] + step;
      act_new = 1'b1;
      lvl_new = (!gate_q[slot_q] || !active_q[slot_q] || rel_q[slot_q]) ? vol_s : lvl_q[slot_q];
    end else if (!gate_s && active_q[slot_q] && (lvl_q[slot_q] != '0)) begin
      // Releasing: held pitch keeps running while the level steps down.
      lvl_new = lvl_q[slot_q];
      if (env_q[slot_q] == ENV_W'(RELEASE_DIV - 1)) begin
        lvl_new = lvl_q[slot_q] - VOL_W'(1);
      end else begin
        env_new = env_q[slot_q] + ENV_W'(1);
      end
      if (lvl_new != '0) begin
        acc_new = acc_q[slot_q] + step_hold;
        act_new = 1'b1;
        rel_new = 1'b1;
      end
    end
`else
    if (valid_s) begin
      acc_new = acc_q[slot_q] + step;
      act_new = 1'b1;
      lvl_new = vol_s;
    end
`endif
    contrib = acc_new[ACC_W-1] ? lvl_new : '0;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_SWEEP;
          slot_d  = '0;
          sum_d   = '0;
        end
      end
      S_SWEEP: begin
        acc_d[slot_q]    = acc_new;
        active_d[slot_q] = act_new;
        sum_d            = sum_q + SUM_W'(contrib);
`ifdef RELEASE_EN
        lvl_d[slot_q]  = lvl_new;
        env_d[slot_q]  = env_new;
        rel_d[slot_q]  = rel_new;
        gate_d[slot_q] = gate_s;
        if (valid_s) begin
          hnote_d[slot_q] = note_s;
          hoct_d[slot_q]  = oct_s;
        end
`endif
        if (slot_q == SLOT_W'(CHANNELS - 1)) begin
          state_d = S_LATCH;
        end else begin
          slot_d = slot_q + SLOT_W'(1);
        end
      end
      S_LATCH: begin
        mix_d   = sum_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      state_q  <= S_IDLE;
      slot_q   <= '0;
      sum_q    <= '0;
      mix_q    <= '0;
      sd_q     <= '0;
      wave_q   <= 1'b0;
      active_q <= '0;
      acc_q    <= '{default: '0};
`ifdef RELEASE_EN
      lvl_q    <= '{default: '0};
      env_q    <= '{default: '0};
      hnote_q  <= '{default: '0};
      hoct_q   <= '{default: '0};
      gate_q   <= '0;
      rel_q    <= '0;
`endif
    end else begin
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      slot_q   <= slot_d;
      sum_q    <= sum_d;
      mix_q    <= mix_d;
      sd_q     <= sd_d;
      wave_q   <= wave_d;
      active_q <= active_d;
      acc_q    <= acc_d;
`ifdef RELEASE_EN
      lvl_q    <= lvl_d;
      env_q    <= env_d;
      hnote_q  <= hnote_d;
      hoct_q   <= hoct_d;
      gate_q   <= gate_d;
      rel_q    <= rel_d;
`endif
    end
  end

endmodule

// File: tb/tb_poly_tone_synth.sv
// Randomised and directed bench for poly_tone_synth against a per-tick arithmetic voice/mix model.
module tb_poly_tone_synth;

  localparam int unsigned CH     = 4;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned VOL_W  = 4;
  localparam int unsigned SDIV   = 1024;
  localparam int unsigned SUM_W  = 6;
  localparam int unsigned LATCH_OFS = CH + 2;
  localparam longint unsigned ACC_MASK = (64'd1 << ACC_W) - 64'd1;
  localparam longint unsigned ACC_HALF = 64'd1 << (ACC_W - 1);

  logic                  clk = 1'b0;
  logic                  rst;
  logic [4*CH-1:0]       ch_note, ch_octave;
  logic [CH-1:0]         ch_gate;
  logic [VOL_W*CH-1:0]   ch_volume;
  logic                  wave;
  logic [CH-1:0]         active;

  int t_note [CH];
  int t_oct  [CH];
  int t_vol  [CH];
  bit t_gate [CH];

  longint unsigned inc_tb [16];
  longint unsigned m_acc  [CH];
  int              m_act;
  int              m_mix;

  int n_checks = 0;
  int n_pass   = 0;

  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign ch_note[4*g +: 4]           = 4'(t_note[g]);
    assign ch_octave[4*g +: 4]         = 4'(t_oct[g]);
    assign ch_gate[g]                  = t_gate[g];
    assign ch_volume[VOL_W*g +: VOL_W] = VOL_W'(t_vol[g]);
  end

  poly_tone_synth #(
    .CHANNELS(CH), .CLK_HZ(100000000), .SAMPLE_DIV(SDIV),
    .ACC_W(ACC_W), .VOL_W(VOL_W), .RELEASE_DIV(4096)
  ) dut (
    .clk(clk), .rst(rst), .ch_note(ch_note), .ch_octave(ch_octave),
    .ch_gate(ch_gate), .ch_volume(ch_volume), .wave(wave), .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic longint unsigned mhz(input int n);
    case (n)
      1: return 64'd4186009;   2: return 64'd4434922;   3: return 64'd4698636;
      4: return 64'd4978032;   5: return 64'd5274041;   6: return 64'd5587652;
      7: return 64'd5919911;   8: return 64'd6271927;   9: return 64'd6644875;
      10: return 64'd7040000;  11: return 64'd7458620;  12: return 64'd7902133;
      default: return 64'd0;
    endcase
  endfunction

  // One sample tick of every voice, straight from the note/octave/gate rules.
  task automatic model_tick();
    int sum;
    sum = 0;
    for (int i = 0; i < CH; i++) begin
      if (t_gate[i] && t_note[i] >= 1 && t_note[i] <= 12 && t_oct[i] <= 8) begin
        m_acc[i] = (m_acc[i] + (inc_tb[t_note[i]] >> (8 - t_oct[i]))) & ACC_MASK;
        m_act[i] = 1'b1;
        if (m_acc[i] >= ACC_HALF) sum += t_vol[i];
      end else begin
        m_acc[i] = 0;
        m_act[i] = 1'b0;
      end
    end
    m_mix = sum;
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) m_acc[i] = 0;
    m_act = 0;
    m_mix = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_mix"}, longint'(dut.mix_q), m_mix);
    check({tag, "_active"}, longint'(active), m_act);
    for (int i = 0; i < CH; i++)
      check($sformatf("%s_acc%0d", tag, i), longint'(dut.acc_q[i]), longint'(m_acc[i]));
  endtask

  // Advance one sample period from just after a mix latch; the window's ones must equal SDIV*mix/2^SUM_W.
  task automatic step(input string tag);
    int ones;
    int exp_ones;
    ones = 0;
    exp_ones = (int'(SDIV) * m_mix) >>> SUM_W;
    for (int c = 0; c < int'(SDIV); c++) begin
      @(posedge clk); #1;
      ones += int'(wave);
    end
    model_tick();
    check({tag, "_ones"}, ones, exp_ones);
    check_state(tag);
  endtask

  // From reset release up to just after the first mix latch; nothing may sound before it.
  task automatic sync_after_reset(input string tag);
    int ones;
    int nz;
    ones = 0;
    nz = 0;
    for (int c = 0; c < int'(SDIV + LATCH_OFS - 1); c++) begin
      @(posedge clk); #1;
      ones += int'(wave);
      if (c < int'(SDIV + LATCH_OFS - 2) && dut.mix_q != '0) nz++;
    end
    model_tick();
    check({tag, "_ones"}, ones, 0);
    check({tag, "_premix"}, nz, 0);
    check_state(tag);
  endtask

  task automatic set_voice(input int i, input int note, input int oct, input bit gate, input int vol);
    t_note[i] = note;
    t_oct[i]  = oct;
    t_gate[i] = gate;
    t_vol[i]  = vol;
  endtask

  initial begin
    longint unsigned pre;
    for (int n = 0; n < 16; n++)
      inc_tb[n] = (mhz(n) * (64'd1 << ACC_W) * 64'(SDIV) + 64'd50000000000) / 64'd100000000000;
    for (int i = 0; i < CH; i++) set_voice(i, 0, 0, 1'b0, 0);
    model_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_wave", longint'(wave), 0);
    check("rst_active", longint'(active), 0);
    rst = 1'b0;
    sync_after_reset("init");

    // Voice 0 on A8 at full volume: MSB rises after 7 ticks.
    set_voice(0, 10, 8, 1'b1, 15);
    for (int k = 0; k < 9; k++) step($sformatf("a8_%0d", k));
    check("a8_mix_high", longint'(dut.mix_q), 15);

    // Asynchronous reset in the middle of a sweep.
    repeat (SDIV - 3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_wave", longint'(wave), 0);
    check("mid_rst_active", longint'(active), 0);
    check("mid_rst_mix", longint'(dut.mix_q), 0);
    check("mid_rst_acc0", longint'(dut.acc_q[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    sync_after_reset("post_rst");
    check("a8_inc", longint'(dut.acc_q[0]), 1209463);

    // Two voices gated together stay phase-locked.
    t_gate[0] = 1'b0;
    step("gate_off");
    set_voice(0, 10, 8, 1'b1, 15);
    set_voice(1, 10, 8, 1'b1, 15);
    for (int k = 0; k < 9; k++) step($sformatf("duo_%0d", k));
    check("duo_mix_high", longint'(dut.mix_q), 30);

    // Voice 2 rests: note 0, note 13, octave 9; then C0.
    set_voice(2, 0, 4, 1'b1, 9);
    step("rest_n0");
    t_note[2] = 13;
    step("rest_n13");
    t_note[2] = 10; t_oct[2] = 9;
    step("rest_o9");
    t_note[2] = 1; t_oct[2] = 0;
    step("c0");
    check("c0_inc", longint'(dut.acc_q[2]), longint'(inc_tb[1] >> 8));

    // Retune A4 -> A5 without phase reset.
    t_oct[0] = 4;
    pre = m_acc[0];
    step("a4");
    check("a4_inc", longint'((64'(dut.acc_q[0]) - pre) & ACC_MASK), 75591);
    t_oct[0] = 5;
    pre = m_acc[0];
    step("a5");
    check("a5_inc", longint'((64'(dut.acc_q[0]) - pre) & ACC_MASK), 151182);

    // Random voice traffic.
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 1) != 0) begin
          t_gate[i] = ($urandom_range(0, 3) != 0);
          t_note[i] = ($urandom_range(0, 4) != 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(0, 15));
          t_oct[i]  = ($urandom_range(0, 4) != 0) ? int'($urandom_range(5, 8)) : int'($urandom_range(0, 15));
          t_vol[i]  = int'($urandom_range(0, 15));
        end
      end
      step($sformatf("rnd_%0d", k));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
